// File: rtl/phase_sequencer_pkg.sv
// ============================================================================
// Module      : cpu12_pkg
// Description : Shared sequencer state encoding, index-width helper and the
//               default phase / interrupt-line counts used by the 12-bit core.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package cpu12_pkg;

    localparam int DEF_NUM_PHASES = 3;
    localparam int DEF_IRQ_LINES  = 24;

    // The phase index is kept beside the state, not folded into it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_INT   = 2'd2
    } seq_state_e;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_sequencer_if.sv
// ============================================================================
// Module      : phase_sequencer_if
// Description : Control, interrupt and status bundle of the phase sequencer.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

interface phase_sequencer_if
    import cpu12_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int IRQ_LINES  = DEF_IRQ_LINES,
    parameter int WS_W       = 4
) ();
    localparam int IDX_W = idx_w(IRQ_LINES);

    logic                  hold;
    logic                  mem_ready;
    logic [WS_W-1:0]       wait_states;
    logic                  end_early;
    logic                  int_en;
    logic [IRQ_LINES-1:0]  irq_mask;
    logic [IRQ_LINES-1:0]  irq;
    logic [NUM_PHASES-1:0] phase;
    logic                  int_phase;
    logic                  irq_taken;
    logic [IDX_W-1:0]      irq_vector;
    logic                  stalled;
    logic                  cycle_done;
    logic [IRQ_LINES-1:0]  pending;

    modport master (
        output hold, mem_ready, wait_states, end_early, int_en, irq_mask, irq,
        input  phase, int_phase, irq_taken, irq_vector, stalled, cycle_done, pending
    );

    modport slave (
        input  hold, mem_ready, wait_states, end_early, int_en, irq_mask, irq,
        output phase, int_phase, irq_taken, irq_vector, stalled, cycle_done, pending
    );

endinterface

`default_nettype wire

// File: rtl/phase_sequencer_irq_latch.sv
// ============================================================================
// Module      : irq_latch
// Description : Rising-edge interrupt capture, pending register, masking and
//               lowest-index-first priority encoding.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module irq_latch
    import cpu12_pkg::*;
#(
    parameter int IRQ_LINES = DEF_IRQ_LINES,
    parameter int IDX_W     = idx_w(DEF_IRQ_LINES)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [IRQ_LINES-1:0] irq,
    input  wire logic [IRQ_LINES-1:0] irq_mask,
    input  wire logic                 clr_en,
    input  wire logic [IDX_W-1:0]     clr_idx,
    output logic      [IRQ_LINES-1:0] pending,
    output logic                      any_eligible,
    output logic      [IDX_W-1:0]     win_idx
);

    logic [IRQ_LINES-1:0] r_irq_d;
    logic [IRQ_LINES-1:0] r_pending;
    logic [IRQ_LINES-1:0] w_clr;
    logic [IRQ_LINES-1:0] w_elig;
    logic [IDX_W-1:0]     w_idx;

    assign w_clr  = clr_en ? (IRQ_LINES'(1) << clr_idx) : '0;
    assign w_elig = r_pending & irq_mask;

    // A fresh edge is OR-ed in after the clear so it survives a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_d   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_d   <= irq;
            r_pending <= (r_pending & ~w_clr) | (irq & ~r_irq_d);
        end
    end

    always_comb begin
        w_idx = '0;
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign pending      = r_pending;
    assign any_eligible = |w_elig;
    assign win_idx      = w_idx;

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ============================================================================
// Module      : phase_sequencer
// Description : One-hot instruction phase generator with wait states, early
//               termination and boundary interrupt-entry insertion.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module phase_sequencer
    import cpu12_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int IRQ_LINES  = DEF_IRQ_LINES,
    parameter int WS_W       = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    phase_sequencer_if.slave bus
);

    localparam int IDX_W = idx_w(IRQ_LINES);
    localparam int PH_W  = idx_w(NUM_PHASES);

    localparam logic [1:0]      c_st_idle  = ST_IDLE;
    localparam logic [1:0]      c_st_phase = ST_PHASE;
    localparam logic [1:0]      c_st_int   = ST_INT;
    localparam logic [PH_W-1:0] c_last_ph  = PH_W'(NUM_PHASES - 1);

    logic [1:0]       r_state;
    logic [PH_W-1:0]  r_ph_idx;
    logic [WS_W-1:0]  r_cnt;
    logic [IDX_W-1:0] r_vec;
    logic             r_done;

    logic             w_in_phase;
    logic             w_in_int;
    logic             w_complete;
    logic             w_boundary;
    logic             w_take_int;
    logic             w_clr_en;
    logic             w_any_elig;
    logic [IDX_W-1:0] w_win_idx;

    irq_latch #(
        .IRQ_LINES (IRQ_LINES),
        .IDX_W     (IDX_W)
    ) u_irq_latch (
        .clk          (clk),
        .rst          (rst),
        .irq          (bus.irq),
        .irq_mask     (bus.irq_mask),
        .clr_en       (w_clr_en),
        .clr_idx      (r_vec),
        .pending      (bus.pending),
        .any_eligible (w_any_elig),
        .win_idx      (w_win_idx)
    );

    assign w_in_phase = (r_state == c_st_phase);
    assign w_in_int   = (r_state == c_st_int);
    assign w_complete = w_in_phase && !bus.hold && (r_cnt == '0) && bus.mem_ready;
    assign w_boundary = w_complete && ((r_ph_idx == c_last_ph) || bus.end_early);
    assign w_take_int = w_boundary && bus.int_en && w_any_elig;
    assign w_clr_en   = w_in_int && !bus.hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_st_idle;
            r_ph_idx <= '0;
            r_cnt    <= '0;
            r_vec    <= '0;
            r_done   <= 1'b0;
        end else if (!bus.hold) begin
            // cycle_done is owed for the first unheld cycle after a boundary.
            r_done <= w_boundary;
            case (r_state)
                c_st_idle: begin
                    r_state  <= c_st_phase;
                    r_ph_idx <= '0;
                    r_cnt    <= bus.wait_states;
                end
                c_st_phase: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - WS_W'(1);
                    end else if (w_take_int) begin
                        r_state <= c_st_int;
                        r_vec   <= w_win_idx;
                    end else if (w_boundary) begin
                        r_ph_idx <= '0;
                        r_cnt    <= bus.wait_states;
                    end else if (w_complete) begin
                        r_ph_idx <= r_ph_idx + PH_W'(1);
                        r_cnt    <= bus.wait_states;
                    end
                end
                c_st_int: begin
                    r_state  <= c_st_phase;
                    r_ph_idx <= '0;
                    r_cnt    <= bus.wait_states;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.phase      = w_in_phase ? (NUM_PHASES'(1) << r_ph_idx) : '0;
    assign bus.int_phase  = w_in_int;
    assign bus.irq_taken  = w_in_int && !bus.hold;
    assign bus.irq_vector = bus.irq_taken ? r_vec : '0;
    assign bus.stalled    = w_in_phase && !bus.hold && ((r_cnt != '0) || !bus.mem_ready);
    assign bus.cycle_done = r_done && !bus.hold;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// Module      : tb_phase_sequencer
// Description : Directed plus randomized bench against a cycle-level
//               behavioural model of the phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

    localparam int NP = 3;
    localparam int NL = 24;
    localparam int WW = 4;

    localparam int M_IDLE  = 0;
    localparam int M_PHASE = 1;
    localparam int M_INT   = 2;

    logic clk;
    logic rst;

    phase_sequencer_if #(.NUM_PHASES(NP), .IRQ_LINES(NL), .WS_W(WW)) bus ();

    phase_sequencer #(.NUM_PHASES(NP), .IRQ_LINES(NL), .WS_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_stall = 0;
    int seen_vec[$];

    // Behavioural reference state
    int          m_mode;
    int          m_k;
    int          m_wait;
    int          m_vec;
    bit          m_done;
    logic [NL-1:0] m_pend;
    logic [NL-1:0] m_irqd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int lowest(input logic [NL-1:0] v);
        for (int i = 0; i < NL; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_k = 0; m_wait = 0; m_vec = 0; m_done = 0;
        m_pend = '0; m_irqd = '0;
    endtask

    task automatic enter(input int j);
        m_mode = M_PHASE; m_k = j; m_wait = int'(bus.wait_states);
    endtask

    task automatic model_update();
        logic [NL-1:0] edges, clr, elig;
        bit fin, bnd;
        edges  = bus.irq & ~m_irqd;
        m_irqd = bus.irq;
        clr    = '0;
        if (!bus.hold) begin
            if (m_mode == M_INT) clr[m_vec] = 1'b1;
            fin    = (m_mode == M_PHASE) && (m_wait == 0) && bus.mem_ready;
            bnd    = fin && ((m_k == NP - 1) || bus.end_early);
            m_done = bnd;
            if (m_mode != M_PHASE) enter(0);
            else if (m_wait > 0) m_wait--;
            else if (bnd) begin
                elig = m_pend & bus.irq_mask;
                if (bus.int_en && elig != '0) begin
                    m_mode = M_INT;
                    m_vec  = lowest(elig);
                end else enter(0);
            end else if (fin) enter(m_k + 1);
        end
        m_pend = (m_pend & ~clr) | edges;
    endtask

    // Starts and ends on a falling edge; inputs must already be set.
    task automatic step();
        logic [NP-1:0] e_ph;
        bit e_taken;
        #1;
        e_ph    = (m_mode == M_PHASE) ? (NP'(1) << m_k) : '0;
        e_taken = (m_mode == M_INT) && !bus.hold;
        chk("phase", 32'(bus.phase), 32'(e_ph));
        chk("int_phase", 32'(bus.int_phase), 32'(m_mode == M_INT));
        chk("irq_taken", 32'(bus.irq_taken), 32'(e_taken));
        chk("irq_vector", 32'(bus.irq_vector), e_taken ? 32'(m_vec) : 32'd0);
        chk("stalled", 32'(bus.stalled),
            32'((m_mode == M_PHASE) && !bus.hold && (m_wait > 0 || !bus.mem_ready)));
        chk("cycle_done", 32'(bus.cycle_done), 32'(m_done && !bus.hold));
        chk("pending", 32'(bus.pending), 32'(m_pend));
        if (bus.irq_taken) seen_vec.push_back(int'(bus.irq_vector));
        if (bus.stalled) n_stall++;
        @(posedge clk);
        if (rst) model_update();
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_phase"}, 32'(bus.phase), 32'd0);
        chk({tag, "_intph"}, 32'(bus.int_phase), 32'd0);
        chk({tag, "_taken"}, 32'(bus.irq_taken), 32'd0);
        chk({tag, "_stall"}, 32'(bus.stalled), 32'd0);
        chk({tag, "_done"}, 32'(bus.cycle_done), 32'd0);
        chk({tag, "_pend"}, 32'(bus.pending), 32'd0);
        chk({tag, "_vec"}, 32'(bus.irq_vector), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, len, s0, n;
        bit dropped;

        rst = 1'b0;
        bus.hold = 0; bus.mem_ready = 1; bus.wait_states = '0; bus.end_early = 0;
        bus.int_en = 1; bus.irq_mask = '1; bus.irq = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #3;
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_done", 32'(bus.cycle_done), 32'd0);
        chk("rst_pend", 32'(bus.pending), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Free run: 000, 001, 010, 100, 001, ...
        repeat (8) step();

        // Two wait states into PHASE(1), then one not-ready cycle
        for (n = 0; n < 20 && !(m_mode == M_PHASE && m_k == 0); n++) step();
        chk("ws_align", 32'(m_mode == M_PHASE && m_k == 0), 32'd1);
        bus.wait_states = 4'd2;
        step();
        bus.wait_states = '0;
        len = 0; s0 = n_stall; dropped = 0;
        while (m_mode == M_PHASE && m_k == 1 && len < 20) begin
            bus.mem_ready = !(m_wait == 0 && !dropped);
            if (!bus.mem_ready) dropped = 1;
            len++;
            step();
        end
        bus.mem_ready = 1;
        chk("ws_len", 32'(len), 32'd4);
        chk("ws_stall", 32'(n_stall - s0), 32'd3);

        // Early end on the PHASE(1) completion
        for (n = 0; n < 20 && !(m_mode == M_PHASE && m_k == 1); n++) step();
        bus.end_early = 1;
        step();
        bus.end_early = 0;
        #1;
        chk("early_phase", 32'(bus.phase), 32'd1);
        chk("early_done", 32'(bus.cycle_done), 32'd1);
        step();
        chk("early_skip", 32'(bus.phase), 32'd2);

        // Priority: 17 and 5 together, 5 first
        base = seen_vec.size();
        for (n = 0; n < 20 && !(m_mode == M_PHASE && m_k == 0); n++) step();
        bus.irq[17] = 1; bus.irq[5] = 1;
        step();
        bus.irq = '0;
        for (n = 0; n < 40 && seen_vec.size() < base + 2; n++) step();
        chk("prio_count", 32'(seen_vec.size() - base), 32'd2);
        if (seen_vec.size() >= base + 2) begin
            chk("prio_first", 32'(seen_vec[base]), 32'd5);
            chk("prio_second", 32'(seen_vec[base + 1]), 32'd17);
        end

        // Masked line latches but waits for its mask bit
        base = seen_vec.size();
        bus.irq_mask = ~(NL'(1) << 3);
        bus.irq[3] = 1;
        step();
        bus.irq = '0;
        repeat (12) step();
        chk("mask_noint", 32'(seen_vec.size()), 32'(base));
        chk("mask_latched", 32'(bus.pending[3]), 32'd1);
        bus.irq_mask = '1;
        for (n = 0; n < 20 && seen_vec.size() == base; n++) step();
        chk("mask_vec", (seen_vec.size() > base) ? 32'(seen_vec[base]) : 32'hFFFF, 32'd3);

        // Hold in the middle of a wait stretch
        for (n = 0; n < 20 && !(m_mode == M_PHASE && m_k == 0); n++) step();
        bus.wait_states = 4'd3;
        step();
        bus.wait_states = '0;
        step();
        bus.hold = 1;
        repeat (3) step();
        bus.hold = 0;
        #1;
        chk("hold_phase", 32'(bus.phase), 32'd2);
        repeat (6) step();

        // Hold over an interrupt-entry cycle: exactly one pulse
        base = seen_vec.size();
        bus.irq[11] = 1;
        step();
        bus.irq = '0;
        for (n = 0; n < 20 && m_mode != M_INT; n++) step();
        chk("hold_int_reach", 32'(m_mode), 32'(M_INT));
        bus.hold = 1;
        repeat (3) step();
        bus.hold = 0;
        repeat (4) step();
        chk("hold_int_once", 32'(seen_vec.size() - base), 32'd1);

        // New irq[3] edge during its own INT cycle is kept
        bus.irq[3] = 1;
        step();
        bus.irq = '0;
        for (n = 0; n < 20 && !(m_mode == M_INT && m_vec == 3); n++) step();
        bus.irq[3] = 1;
        step();
        bus.irq = '0;
        chk("collide_pend", 32'(bus.pending[3]), 32'd1);
        repeat (8) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.hold        = ($urandom_range(7) == 0);
            bus.mem_ready   = ($urandom_range(3) != 0);
            bus.wait_states = WW'($urandom_range(3));
            bus.end_early   = ($urandom_range(7) == 0);
            bus.int_en      = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) bus.irq_mask = NL'($urandom);
            bus.irq         = bus.irq ^ (NL'($urandom) & NL'($urandom) & NL'($urandom));
            step();
        end
        bus.hold = 0; bus.mem_ready = 1; bus.wait_states = '0; bus.end_early = 0;
        bus.int_en = 1; bus.irq_mask = '1; bus.irq = '0;
        repeat (4) step();

        // Asynchronous reset during INT
        bus.irq[9] = 1;
        step();
        bus.irq = '0;
        for (n = 0; n < 20 && m_mode != M_INT; n++) step();
        chk("rint_reach", 32'(m_mode), 32'(M_INT));
        async_reset("rint");
        repeat (5) step();

        // Asynchronous reset during a wait stretch
        bus.wait_states = 4'd5;
        for (n = 0; n < 20 && !(m_mode == M_PHASE && m_wait > 0); n++) step();
        bus.wait_states = '0;
        async_reset("rws");
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
